// File: rtl/uart_cmd_if_if.sv
// Command-side bundle between the UART front end and the command block.
// The front end drives the slave modport; the command block drives the master modport.
interface uart_cmd_if_if;
   // cmd/cmd_rdy: cmd is valid and held stable while cmd_rdy=1, released by a one-cycle clr_cmd_rdy.
   // send_resp/resp_sent: resp is sampled with the send_resp pulse; resp_sent pulses once when the byte is out.
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent;

   modport master (
      input  cmd, cmd_rdy, resp_sent,
      output clr_cmd_rdy, resp, send_resp
   );

   modport slave (
      output cmd, cmd_rdy, resp_sent,
      input  clr_cmd_rdy, resp, send_resp
   );
endinterface

// File: rtl/uart_cmd_if.sv
// Host UART front end: assembles byte pairs from RX into 16-bit commands
// and serializes single response bytes onto TX (8N1, BAUD_DIV clocks per bit).
module uart_cmd_if #(
   parameter int BAUD_DIV = 1736
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   output logic              TX,
   uart_cmd_if_if.slave      bus,
   output logic [3:0]        o_dbg_state
);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic       {ASM_HIGH, ASM_LOW}                   asm_state_t;
   typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

   localparam logic [11:0] C_BAUD = 12'(BAUD_DIV);
   localparam logic [11:0] C_HALF = 12'(BAUD_DIV / 2);

   logic        r_rx_meta;
   logic        r_rx_s;
   logic        r_rx_prev;
   rx_state_t   r_rx_state;
   logic [11:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_byte;

   rx_state_t   w_rx_state_nxt;
   logic [11:0] w_rx_cnt_nxt;
   logic [2:0]  w_rx_bit_nxt;
   logic        w_rx_shift;
   logic        w_rx_done;
   logic        w_rx_expire;

   asm_state_t  r_asm_state;
   logic [15:0] r_cmd;
   logic        r_cmd_rdy;

   asm_state_t  w_asm_state_nxt;
   logic [15:0] w_cmd_nxt;
   logic        w_cmd_rdy_nxt;

   tx_state_t   r_tx_state;
   logic [9:0]  r_tx_shift;
   logic [11:0] r_tx_cnt;
   logic [3:0]  r_tx_bit;
   logic        r_resp_sent;

   tx_state_t   w_tx_state_nxt;
   logic [9:0]  w_tx_shift_nxt;
   logic [11:0] w_tx_cnt_nxt;
   logic [3:0]  w_tx_bit_nxt;
   logic        w_resp_sent_nxt;

   // Receive path: synchronizer, previous-sample flop for edge detect, and FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= C_HALF;
         r_rx_bit   <= 3'd0;
         r_rx_byte  <= 8'h00;
      end else begin
         r_rx_meta  <= RX;
         r_rx_s     <= r_rx_meta;
         r_rx_prev  <= r_rx_s;
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         if (w_rx_shift) begin
            r_rx_byte <= {r_rx_s, r_rx_byte[7:1]};
         end
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt - 12'd1;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift     = 1'b0;
      w_rx_done      = 1'b0;
      w_rx_expire    = (r_rx_cnt == 12'd1);
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = C_HALF;
            w_rx_bit_nxt = 3'd0;
            if (r_rx_prev && !r_rx_s) begin
               w_rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (w_rx_expire) begin
               if (r_rx_s) begin
                  w_rx_state_nxt = RX_IDLE;
               end else begin
                  w_rx_state_nxt = RX_DATA;
                  w_rx_cnt_nxt   = C_BAUD;
               end
            end
         end
         RX_DATA: begin
            if (w_rx_expire) begin
               w_rx_shift   = 1'b1;
               w_rx_cnt_nxt = C_BAUD;
               if (r_rx_bit == 3'd7) begin
                  w_rx_state_nxt = RX_STOP;
               end else begin
                  w_rx_bit_nxt = r_rx_bit + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (w_rx_expire) begin
               w_rx_state_nxt = RX_IDLE;
               w_rx_done      = r_rx_s;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   // Command assembler: bytes arriving while a command is still held are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_asm_state <= ASM_HIGH;
         r_cmd       <= 16'h0000;
         r_cmd_rdy   <= 1'b0;
      end else begin
         r_asm_state <= w_asm_state_nxt;
         r_cmd       <= w_cmd_nxt;
         r_cmd_rdy   <= w_cmd_rdy_nxt;
      end
   end

   always_comb begin
      w_asm_state_nxt = r_asm_state;
      w_cmd_nxt       = r_cmd;
      w_cmd_rdy_nxt   = r_cmd_rdy;
      if (bus.clr_cmd_rdy) begin
         w_cmd_rdy_nxt = 1'b0;
      end
      if (w_rx_done && !r_cmd_rdy) begin
         case (r_asm_state)
            ASM_HIGH: begin
               w_cmd_nxt       = {r_rx_byte, r_cmd[7:0]};
               w_asm_state_nxt = ASM_LOW;
            end
            ASM_LOW: begin
               w_cmd_nxt       = {r_cmd[15:8], r_rx_byte};
               w_cmd_rdy_nxt   = 1'b1;
               w_asm_state_nxt = ASM_HIGH;
            end
            default: w_asm_state_nxt = ASM_HIGH;
         endcase
      end
   end

   // Transmit path: 10-bit frame shifted out LSB first, refilled with idle ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state  <= TX_IDLE;
         r_tx_shift  <= 10'h3FF;
         r_tx_cnt    <= C_BAUD;
         r_tx_bit    <= 4'd0;
         r_resp_sent <= 1'b0;
      end else begin
         r_tx_state  <= w_tx_state_nxt;
         r_tx_shift  <= w_tx_shift_nxt;
         r_tx_cnt    <= w_tx_cnt_nxt;
         r_tx_bit    <= w_tx_bit_nxt;
         r_resp_sent <= w_resp_sent_nxt;
      end
   end

   always_comb begin
      w_tx_state_nxt  = r_tx_state;
      w_tx_shift_nxt  = r_tx_shift;
      w_tx_cnt_nxt    = r_tx_cnt - 12'd1;
      w_tx_bit_nxt    = r_tx_bit;
      w_resp_sent_nxt = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_cnt_nxt = C_BAUD;
            w_tx_bit_nxt = 4'd0;
            if (bus.send_resp) begin
               w_tx_shift_nxt = {1'b1, bus.resp, 1'b0};
               w_tx_state_nxt = TX_XMIT;
            end
         end
         TX_XMIT: begin
            if (r_tx_cnt == 12'd1) begin
               w_tx_shift_nxt = {1'b1, r_tx_shift[9:1]};
               w_tx_cnt_nxt   = C_BAUD;
               if (r_tx_bit == 4'd9) begin
                  w_tx_state_nxt  = TX_IDLE;
                  w_resp_sent_nxt = 1'b1;
               end else begin
                  w_tx_bit_nxt = r_tx_bit + 4'd1;
               end
            end
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
   end

   assign TX            = r_tx_shift[0];
   assign bus.cmd       = r_cmd;
   assign bus.cmd_rdy   = r_cmd_rdy;
   assign bus.resp_sent = r_resp_sent;
   assign o_dbg_state   = {r_rx_state, r_asm_state, r_tx_state};

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if at BAUD_DIV=16: command assembly, hold/clear,
// response serialization, glitch/framing rejection, reset abort and RX/TX concurrency.
module tb_uart_cmd_if;

   localparam int BAUD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [3:0]  dbg_state;
   logic        abort = 1'b0;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          last_start_cyc = 0;
   int          rdy_rise_cyc = 0;
   logic        rdy_prev = 1'b0;
   logic [15:0] exp_q[$];

   uart_cmd_if_if bus ();

   uart_cmd_if #(.BAUD_DIV(BAUD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // Clock and cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rising cmd_rdy must match the oldest expected command.
   always @(negedge clk) begin
      if (bus.cmd_rdy && !rdy_prev) begin
         rdy_rise_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("cmd_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            chk("cmd", 32'(bus.cmd), 32'(exp_q.pop_front()));
         end
      end
      rdy_prev = bus.cmd_rdy;
   end

   task automatic uart_send(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      last_start_cyc = cyc;
      for (int i = 0; i < 10 * BAUD; i++) begin
         if (abort) break;
         RX = f[4'(i / BAUD)];
         @(negedge clk);
      end
      RX = 1'b1;
   endtask

   task automatic clear_rdy(input logic [15:0] exp_cmd);
      chk("rdy_before_clear", 32'(bus.cmd_rdy), 32'd1);
      bus.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      bus.clr_cmd_rdy = 1'b0;
      chk("rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
      chk("cmd_kept", 32'(bus.cmd), 32'(exp_cmd));
   endtask

   // Sends one response and checks TX every cycle; inject>=0 adds an ignored send_resp.
   task automatic tx_check(input logic [7:0] b, input int inject);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      bus.resp = b;
      bus.send_resp = 1'b1;
      @(negedge clk);
      bus.send_resp = 1'b0;
      for (int k = 0; k <= 10 * BAUD + 1; k++) begin
         if (k < 10 * BAUD) chk("tx_bit", 32'(TX), 32'(f[4'(k / BAUD)]));
         else chk("tx_idle", 32'(TX), 32'd1);
         chk("resp_sent", 32'(bus.resp_sent), 32'(k == 10 * BAUD));
         if (k == inject) begin
            bus.resp = ~b;
            bus.send_resp = 1'b1;
         end else begin
            bus.send_resp = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_tx"}, 32'(TX), 32'd1);
      chk({tag, "_cmd"}, 32'(bus.cmd), 32'h0000);
      chk({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'd0);
      chk({tag, "_resp_sent"}, 32'(bus.resp_sent), 32'd0);
   endtask

   initial begin
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp   = 1'b0;
      bus.resp        = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      chk("reset_state", 32'(dbg_state), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Basic command with completion latency
      exp_q.push_back(16'h450A);
      uart_send(8'h45, 1'b1);
      chk("asm_low_after_first", 32'(dbg_state[1]), 32'd1);
      uart_send(8'h0A, 1'b1);
      chk("rdy_latency", 32'(rdy_rise_cyc - last_start_cyc), 32'd155);

      // Bytes arriving while held are dropped
      uart_send(8'h12, 1'b1);
      uart_send(8'h34, 1'b1);
      chk("cmd_held", 32'(bus.cmd), 32'h450A);
      chk("asm_high_while_held", 32'(dbg_state[1]), 32'd0);
      clear_rdy(16'h450A);
      exp_q.push_back(16'hA001);
      uart_send(8'hA0, 1'b1);
      uart_send(8'h01, 1'b1);
      clear_rdy(16'hA001);

      // Response with an ignored second request at cycle 50
      repeat (3) @(negedge clk);
      tx_check(8'hA5, 50);

      // Glitch on RX
      RX = 1'b0;
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_state", 32'(dbg_state), 32'h0);
      chk("glitch_rdy", 32'(bus.cmd_rdy), 32'd0);

      // Framing error frame is discarded
      uart_send(8'h55, 1'b0);
      repeat (20) @(negedge clk);
      chk("frame_err_asm", 32'(dbg_state[1]), 32'd0);
      chk("frame_err_cmd", 32'(bus.cmd), 32'hA001);
      exp_q.push_back(16'h1234);
      uart_send(8'h12, 1'b1);
      uart_send(8'h34, 1'b1);

      // Reset mid-RX and mid-TX while a command is held
      bus.resp = 8'hC3;
      bus.send_resp = 1'b1;
      @(negedge clk);
      bus.send_resp = 1'b0;
      fork
         uart_send(8'h77, 1'b1);
      join_none
      repeat (60) @(negedge clk);
      abort = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values("midframe_reset");
      repeat (3) @(negedge clk);
      abort = 1'b0;
      RX = 1'b1;
      chk("reset_state_hold", 32'(dbg_state), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      exp_q.push_back(16'hFF00);
      uart_send(8'hFF, 1'b1);
      uart_send(8'h00, 1'b1);
      clear_rdy(16'hFF00);

      // RX and TX concurrently
      exp_q.push_back(16'h8033);
      fork
         begin
            uart_send(8'h80, 1'b1);
            uart_send(8'h33, 1'b1);
         end
         tx_check(8'h5A, -1);
      join
      repeat (4) @(negedge clk);
      clear_rdy(16'h8033);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("final_state", 32'(dbg_state), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_if.md
# uart_cmd_if

Host-side serial front end of the logic analyzer's command path, sitting directly upstream of the command/configuration block. It receives 8N1 UART bytes on `RX` and assembles each pair into a 16-bit command, high byte first. It presents the command with a `cmd_rdy` flag and holds it until the command block asserts `clr_cmd_rdy`. It also serializes the single response bytes the command block issues via `send_resp`/`resp` and acknowledges each one with `resp_sent`.

## Interface
- `BAUD_DIV`, default 1736: clocks per bit period. Legal range 16..4095; the counters are 12 bits wide.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  serial input from host, asynchronous, idles high.
- `TX`  out  1  serial output to host, idles high.
- `cmd`  out  16  assembled command: `{first byte, second byte}`.
- `cmd_rdy`  out  1  `cmd` is valid and stable.
- `clr_cmd_rdy`  in  1  single-cycle pulse from the consumer that releases the command.
- `resp`  in  8  response byte, sampled when `send_resp` is high.
- `send_resp`  in  1  single-cycle pulse that starts a response transmission.
- `resp_sent`  out  1  single-cycle pulse when the response stop bit has finished.

## Operation
- **Reset values:** `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `resp_sent`=0. Both RX synchronizer flops preset to 1. Receive FSM in IDLE, assembler in HIGH, transmit FSM in IDLE.
- **RX synchronizer:** two flops. All receive logic uses only the second flop output (`rx_s`).
- **Receive FSM (IDLE, START, DATA, STOP):**
  - IDLE: a falling edge on `rx_s` loads the baud counter with BAUD_DIV/2 (integer division) and moves to START.
  - START: at count expiry, resample. If `rx_s`=1 the edge was a glitch: return to IDLE, no byte. Otherwise reload BAUD_DIV and move to DATA.
  - DATA: sample 8 bits, LSB first, one per BAUD_DIV expiry, shifting right into `rx_byte`.
  - STOP: sample at the next expiry. If `rx_s`=1, pulse internal `rx_done` for one cycle. If `rx_s`=0 (framing error), drop the byte with no `rx_done`. Either way return to IDLE.
- **Assembler (HIGH, LOW):**
  - HIGH, on `rx_done`: load `cmd[15:8]` and move to LOW.
  - LOW, on `rx_done`: load `cmd[7:0]`, set `cmd_rdy`, return to HIGH.
  - While `cmd_rdy`=1, every `rx_done` is discarded. `cmd` is frozen and the assembler stays in HIGH.
  - `clr_cmd_rdy` clears `cmd_rdy` on the next edge. `cmd` keeps its value.
  - If `clr_cmd_rdy` and `rx_done` occur in the same cycle while `cmd_rdy`=1, that byte is discarded.
  - No inter-byte timeout exists. A lone first byte waits indefinitely in LOW.
- **Transmit FSM (IDLE, XMIT):**
  - IDLE, on `send_resp`: latch `{1'b1, resp, 1'b0}` into a 10-bit shift register, clear the bit counter, move to XMIT. `TX` is driven from shift-register bit 0.
  - XMIT: shift right, filling with 1, every BAUD_DIV clocks. After the 10th bit period ends, pulse `resp_sent` and return to IDLE.
  - `send_resp` in XMIT is ignored, and the byte in flight is not disturbed.
- RX and TX are fully independent and may run concurrently.
- Asserting `rst_n` mid-frame aborts both directions immediately and restores every reset value. The next RX falling edge after release starts a fresh frame.

## Timing
- **RX detection:** the start edge is detected 2 cycles after the `RX` pin falls (synchronizer latency).
- **RX sampling:** data bit k is sampled floor(BAUD_DIV/2) + (k+1)·BAUD_DIV cycles after detection. The stop bit is sampled at floor(BAUD_DIV/2) + 9·BAUD_DIV.
- **Command completion:** `rx_done` occurs in the stop-sample cycle, and `cmd_rdy` and `cmd[7:0]` update on the following edge.
- **Command release:** `cmd_rdy` falls one cycle after `clr_cmd_rdy` is sampled high.
- **TX start:** `TX` goes low on the edge after `send_resp` is sampled.
- **TX bit timing:** each bit is held exactly BAUD_DIV cycles.
- **TX completion:** `resp_sent` is high for the single cycle at 10·BAUD_DIV cycles after `TX` fell, and `TX` is already 1.
- **Back-to-back responses:** the earliest accepted follow-up `send_resp` is in the same cycle as `resp_sent`.

## Test plan
- **Basic command:** BAUD_DIV=16; host sends 0x45 then 0x0A. Expect `cmd`=16'h450A and `cmd_rdy`=1 one cycle after the second stop sample. After a `clr_cmd_rdy` pulse, `cmd_rdy`=0 next cycle and `cmd` stays 16'h450A.
- **Hold while ready:** with `cmd_rdy`=1, host sends 0x12, 0x34. Expect `cmd` to stay 16'h450A. After clear, host sends 0xA0, 0x01. Expect `cmd`=16'hA001, proving the assembler resynced to HIGH.
- **Response:** `send_resp` with `resp`=0xA5. Expect `TX` to follow the 0,1,0,1,0,0,1,0,1,1 bit sequence, each bit 16 cycles long, and `resp_sent` to pulse once at cycle 160. A second `send_resp` at cycle 50 leaves the waveform unchanged.
- **Glitch and framing error:** RX low for 4 cycles only; expect no byte. Then a frame with the stop bit held 0; expect it discarded, with the assembler still in HIGH.
- **Reset and concurrency:** assert `rst_n` low mid-RX-byte and mid-TX. Expect `TX`=1, `cmd_rdy`=0, `cmd`=0, and a clean 0xFF, 0x00 pair received afterwards. Separately, run RX of 0x80, 0x33 concurrently with TX of 0x5A; both must complete correctly.
